// File: rtl/enemy_formation_ctrl.sv
// enemy_formation_ctrl
//   Frame-rate controller for the invader swarm. Once per frame it decides the
//   march direction, the formation origin, descent events, and tracks which
//   enemy slots are still alive.
//
// Ports
//   Reset              in   synchronous, active-high reset
//   frame_clk          in   frame-rate clock, one rising edge per video frame
//   start              in   level; begins marching from IDLE or CLEARED
//   hit_valid          in   one-frame pulse: a player shot hit an enemy
//   hit_index          in   slot hit, row-major (row*COLS + col)
//   alive_mask         out  bit i set = slot i alive
//   form_x / form_y    out  formation origin; slot origin = origin + col/row * pitch
//   enemy_direction_X  out  0 = marching left, 1 = marching right
//   enemy_direction_Y  out  high for exactly one frame per descent
//   delete_enemies     out  high while in CLEARED or INVADED
//   wave_clear         out  high in CLEARED
//   invaded            out  high in INVADED
module enemy_formation_ctrl #(
  parameter int COLS         = 8,
  parameter int ROWS         = 4,
  parameter int ENEMY_W      = 50,
  parameter int ENEMY_H      = 44,
  parameter int SPACING_X    = 60,
  parameter int SPACING_Y    = 50,
  parameter int START_X      = 40,
  parameter int START_Y      = 40,
  parameter int STEP_X       = 1,
  parameter int STEP_Y       = 8,
  parameter int LEFT_BOUND   = 0,
  parameter int RIGHT_BOUND  = 639,
  parameter int BOTTOM_BOUND = 420,
  parameter int FRAME_DIV    = 4,
  localparam int N_SLOTS     = COLS * ROWS,
  localparam int IDX_W       = $clog2(N_SLOTS)
) (
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               start,
  input  logic               hit_valid,
  input  logic [IDX_W-1:0]   hit_index,
  output logic [N_SLOTS-1:0] alive_mask,
  output logic [9:0]         form_x,
  output logic [9:0]         form_y,
  output logic               enemy_direction_X,
  output logic               enemy_direction_Y,
  output logic               delete_enemies,
  output logic               wave_clear,
  output logic               invaded
);

  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARCH,
    ST_DESCEND,
    ST_CLEARED,
    ST_INVADED
  } state_e;

  state_e             state_q, state_d;
  logic [9:0]         form_x_q, form_x_d;
  logic [9:0]         form_y_q, form_y_d;
  logic               dir_x_q, dir_x_d;
  logic               dir_y_q, dir_y_d;
  logic [N_SLOTS-1:0] alive_mask_q, alive_mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               delete_q, delete_d;
  logic               wave_clear_q, wave_clear_d;
  logic               invaded_q, invaded_d;

  // Occupancy per column and per row of the current (pre-hit) mask.
  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;
  logic [11:0]     lcol, rcol, brow;
  logic [11:0]     left_ext, right_ext, bot_ext;
  logic            tick;

  // NOTE: every variable assigned in an always_comb gets a default on the
  // first lines of the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    col_any = '0;
    row_any = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (alive_mask_q[r*COLS + c]) begin
          col_any[c] = 1'b1;
          row_any[r] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    lcol = '0;
    rcol = '0;
    brow = '0;
    // Descending scan leaves the lowest occupied column; ascending scans the highest.
    for (int c = COLS - 1; c >= 0; c--) if (col_any[c]) lcol = 12'(c);
    for (int c = 0; c < COLS; c++)      if (col_any[c]) rcol = 12'(c);
    for (int r = 0; r < ROWS; r++)      if (row_any[r]) brow = 12'(r);
  end

  // 12-bit arithmetic leaves headroom above the 10-bit origin so no sum wraps.
  assign left_ext  = 12'(form_x_q) + 12'(lcol * SPACING_X);
  assign right_ext = 12'(form_x_q) + 12'(rcol * SPACING_X) + 12'(ENEMY_W);
  assign bot_ext   = 12'(form_y_q) + 12'(brow * SPACING_Y) + 12'(ENEMY_H);
  assign tick      = (cnt_q == CNT_W'(FRAME_DIV - 1));

  always_comb begin
    state_d      = state_q;
    form_x_d     = form_x_q;
    form_y_d     = form_y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = 1'b0;  // a descent flag lives for exactly one frame
    alive_mask_d = alive_mask_q;
    cnt_d        = cnt_q;

    // Hits land on the same edge as any movement decision, which itself
    // still sees the pre-hit mask.
    if ((state_q == ST_MARCH || state_q == ST_DESCEND) && hit_valid &&
        (int'(hit_index) < N_SLOTS)) begin
      alive_mask_d[hit_index] = 1'b0;
    end

    // An empty swarm wins over any pending tick, turn or descent.
    if (alive_mask_q == '0 &&
        (state_q == ST_IDLE || state_q == ST_MARCH || state_q == ST_DESCEND)) begin
      state_d = ST_CLEARED;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_MARCH;
            cnt_d   = '0;
          end
        end
        ST_MARCH: begin
          if (tick) begin
            cnt_d = '0;
            if ((dir_x_q && (right_ext + 12'(STEP_X) > 12'(RIGHT_BOUND + 1))) ||
                (!dir_x_q && (left_ext < 12'(LEFT_BOUND + STEP_X)))) begin
              form_y_d = form_y_q + 10'(STEP_Y);
              dir_x_d  = ~dir_x_q;
              dir_y_d  = 1'b1;
              state_d  = ST_DESCEND;
            end else if (dir_x_q) begin
              form_x_d = form_x_q + 10'(STEP_X);
            end else begin
              form_x_d = form_x_q - 10'(STEP_X);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DESCEND: begin
          cnt_d   = '0;
          state_d = (bot_ext >= 12'(BOTTOM_BOUND)) ? ST_INVADED : ST_MARCH;
        end
        ST_CLEARED: begin
          if (start) begin
            state_d      = ST_MARCH;
            form_x_d     = 10'(START_X);
            form_y_d     = 10'(START_Y);
            dir_x_d      = 1'b1;
            alive_mask_d = '1;
            cnt_d        = '0;
          end
        end
        default: ;  // ST_INVADED: frozen until Reset
      endcase
    end

    wave_clear_d = (state_d == ST_CLEARED);
    invaded_d    = (state_d == ST_INVADED);
    delete_d     = wave_clear_d || invaded_d;
  end

  // NOTE: this codebase resets synchronously on an active-high Reset, so the
  // reset branch sits inside the clocked block with only frame_clk in the sensitivity list.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and the update order within the block cannot matter.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      form_x_q     <= 10'(START_X);
      form_y_q     <= 10'(START_Y);
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b0;
      alive_mask_q <= '1;
      cnt_q        <= '0;
      delete_q     <= 1'b0;
      wave_clear_q <= 1'b0;
      invaded_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      form_x_q     <= form_x_d;
      form_y_q     <= form_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      alive_mask_q <= alive_mask_d;
      cnt_q        <= cnt_d;
      delete_q     <= delete_d;
      wave_clear_q <= wave_clear_d;
      invaded_q    <= invaded_d;
    end
  end

  assign alive_mask        = alive_mask_q;
  assign form_x            = form_x_q;
  assign form_y            = form_y_q;
  assign enemy_direction_X = dir_x_q;
  assign enemy_direction_Y = dir_y_q;
  assign delete_enemies    = delete_q;
  assign wave_clear        = wave_clear_q;
  assign invaded           = invaded_q;

endmodule
